// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline types: register index, forwarding select and the stage destination record.
// Types only; no timing or backpressure of its own.
package rv_pipe_pkg;

  localparam int RV_REG_AW = 5;

  typedef logic [RV_REG_AW-1:0] reg_idx_t;
  typedef logic [1:0]           fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwrite;
  } stage_dst_t;

  // A stage can supply rs only if it really writes a non-x0 register equal to rs.
  function automatic logic dst_hits(input stage_dst_t dst, input reg_idx_t rs);
    return dst.valid && dst.regwrite && (dst.rd != '0) && (dst.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage instruction fields and pipeline controls in; forwarding selects, stall and stall count out.
// master = pipeline control side, slave = hazard unit.
interface fwd_hazard_unit_if
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW = RV_REG_AW,
  parameter int CNT_W  = 16
);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;
  logic              freeze_i;
  fwd_sel_t          fwd_a_o;
  fwd_sel_t          fwd_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_regwrite_i, id_memread_i, flush_i, freeze_i,
    input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_regwrite_i, id_memread_i, flush_i, freeze_i,
    output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Picks the forwarding source for one EX operand; EX/MEM beats MEM/WB, x0 never forwarded.
// Purely combinational, zero latency, no backpressure.
module fwd_match
  import rv_pipe_pkg::*;
(
  input  reg_idx_t   rs,
  input  logic       use_rs,
  input  stage_dst_t exmem,
  input  stage_dst_t memwb,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (use_rs) begin
      if (dst_hits(exmem, rs)) begin
        sel = FWD_EXMEM;
      end else if (dst_hits(memwb, rs)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding/load-use hazard control from shadow ID/EX, EX/MEM, MEM/WB register-use state.
// Outputs combinational from state and ID inputs; freeze_i holds all state, flush_i kills ID.
module fwd_hazard_unit
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW = RV_REG_AW,
  parameter int CNT_W  = 16
)(
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_unit_if.slave   bus
);

  logic              idex_valid;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic              idex_use_rs1;
  logic              idex_use_rs2;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_regwrite;
  logic              idex_memread;

  stage_dst_t        exmem;
  stage_dst_t        memwb;
  stage_dst_t        idex_dst;

  logic              load_hit;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  assign idex_dst = '{valid: idex_valid, rd: reg_idx_t'(idex_rd), regwrite: idex_regwrite};

  fwd_match u_match_a (
    .rs     (reg_idx_t'(idex_rs1)),
    .use_rs (idex_valid && idex_use_rs1),
    .exmem  (exmem),
    .memwb  (memwb),
    .sel    (bus.fwd_a_o)
  );

  fwd_match u_match_b (
    .rs     (reg_idx_t'(idex_rs2)),
    .use_rs (idex_valid && idex_use_rs2),
    .exmem  (exmem),
    .memwb  (memwb),
    .sel    (bus.fwd_b_o)
  );

  // Load in EX whose result the ID instruction needs next cycle: one bubble covers it.
  assign load_hit = idex_valid && idex_memread && (idex_rd != '0) && bus.id_valid_i &&
                    ((bus.id_use_rs1_i && (bus.id_rs1_i == idex_rd)) ||
                     (bus.id_use_rs2_i && (bus.id_rs2_i == idex_rd)));
  assign stall    = load_hit && !bus.flush_i && !bus.freeze_i;

  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_valid    <= 1'b0;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_use_rs1  <= 1'b0;
      idex_use_rs2  <= 1'b0;
      idex_rd       <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      exmem         <= '0;
      memwb         <= '0;
      stall_cnt     <= '0;
    end else if (!bus.freeze_i) begin
      memwb <= exmem;
      exmem <= idex_dst;
      if (bus.flush_i || stall) begin
        idex_valid    <= 1'b0;
        idex_rs1      <= '0;
        idex_rs2      <= '0;
        idex_use_rs1  <= 1'b0;
        idex_use_rs2  <= 1'b0;
        idex_rd       <= '0;
        idex_regwrite <= 1'b0;
        idex_memread  <= 1'b0;
      end else begin
        idex_valid    <= bus.id_valid_i;
        idex_rs1      <= bus.id_rs1_i;
        idex_rs2      <= bus.id_rs2_i;
        idex_use_rs1  <= bus.id_use_rs1_i;
        idex_use_rs2  <= bus.id_use_rs2_i;
        idex_rd       <= bus.id_rd_i;
        idex_regwrite <= bus.id_regwrite_i;
        idex_memread  <= bus.id_memread_i;
      end
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
